nn_scatter_16: RTL and testbench
================================

Name: nn_scatter_16

Overview:
- Inverse of the layer-output gather path: pops a serial stream of 8-bit activations from the first-word-fall-through input FIFO and scatters them into 16 parallel lane registers.
- The lane registers feed the next layer's neuron inputs.
- The layer controller starts a fill with a requested lane count. The block pops exactly that many words, holds them stable, and pulses done.

Parameters:
- DATA_W, 8, width of one activation value
- N_LANES, 16, number of lane registers (fixed at 16 for this revision)
- IDX_W, 4, lane index width, log2(N_LANES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a fill; sampled only in IDLE
- count  in  5  number of lanes to fill, latched on start; valid 1..16, 0 means empty fill, >16 saturates to 16
- fifo_empty  in  1  input FIFO empty flag
- fifo_data  in  8  FIFO head word, valid whenever fifo_empty=0 (FWFT)
- fifo_rd  out  1  pop strobe; combinational
- lanes  out  128  packed lane registers; lane i occupies bits [8i+7:8i]
- lane_valid  out  16  bit i set once lane i has been written in the current fill
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse when the fill completes

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) has priority over everything, including mid-fill:
  - state=IDLE, idx=0, cnt_q=0
  - lanes=0, lane_valid=0, done=0, busy=0
  - fifo_rd=0 while reset is high
- States: IDLE, LOAD, DONE.
- IDLE:
  - fifo_rd=0.
  - On start=1: cnt_q <= min(count,16), idx <= 0, lane_valid <= 0. lanes keep their old values but are not valid.
  - Then go to DONE if count==0, else go to LOAD.
- LOAD:
  - fifo_rd = ~fifo_empty. A pop occurs in a cycle where fifo_rd=1.
  - On a pop: lanes[idx] <= fifo_data, lane_valid[idx] <= 1, idx <= idx+1.
  - If the pop is on the last lane (idx == cnt_q-1), go to DONE.
  - FIFO empty: stall in LOAD with no pop and no state change. There is no timeout.
  - start is ignored in LOAD.
- DONE:
  - done=1 for exactly this one cycle, fifo_rd=0, then go to IDLE.
  - start is ignored in DONE.
- busy = (state != IDLE).
- Hold behaviour:
  - lanes and lane_valid hold their values after DONE until the next accepted start.
  - Lanes with index >= cnt_q keep their previous data, with lane_valid=0.
- Latency with a never-empty FIFO and count=N:
  - start accepted at edge 0
  - pops on the N cycles after edge 0
  - done high in cycle N+1
  - total N+2 cycles from the start cycle to back in IDLE
- A start back-to-back with done is not accepted. The earliest accepted start is the cycle after done, in IDLE.
- idx never exceeds 15. A 16-lane fill leaves via the last-lane test, not via wrap.
- No arithmetic is performed on the data. Words are passed through unchanged, unsigned bit-exact.

Decomposition:
- Shared package nn_pkg holds:
  - NN_DATA_W=8
  - NN_LANES=16
  - NN_IDX_W=4
  - enum scatter_state_t {S_IDLE, S_LOAD, S_DONE}
- No sub-module. The lane array with per-lane write enable is a generate loop inside the block.

Test Plan:
- Reset mid-fill: count=16, FIFO preloaded 0x10..0x1F, reset asserted after 5 pops.
  - Next cycle: lanes=0, lane_valid=0, busy=0, fifo_rd=0. Exactly 5 words were consumed.
- Full fill: FIFO preloaded 0x00..0x0F, start with count=16.
  - fifo_rd high 16 consecutive cycles, done in cycle 17 after start.
  - lanes[8i+7:8i]=i, lane_valid=16'hFFFF.
- Partial fill with stalls: count=3, FIFO words 0xA1, 0xB2, 0xC3, with the FIFO empty for 4 cycles between the 2nd and 3rd words.
  - No pops during the empty cycles.
  - lane0=0xA1, lane1=0xB2, lane2=0xC3, lane_valid=16'h0007.
  - Lanes 3..15 unchanged from the prior fill.
  - done exactly once.
- Edge counts:
  - count=0 -> zero pops, done the cycle after start, lane_valid=0.
  - count=20 -> exactly 16 pops, lane_valid=16'hFFFF.
- Start ignored while busy: pulse start with count=2 again during a LOAD of count=4.
  - Exactly 4 pops, cnt_q unaffected.
  - A start in the cycle after done is accepted and begins a new fill.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pkg
//  Purpose  : Shared constants and state encoding for the layer-input
//             scatter path (FIFO stream -> parallel lane registers).
//  Contents : NN_DATA_W - activation width
//             NN_LANES  - number of lane registers
//             NN_IDX_W  - lane index width
//             scatter_state_t - scatter controller states
//  Revision : 1.0  initial release
// ============================================================================
package nn_pkg;

    localparam int NN_DATA_W = 8;
    localparam int NN_LANES  = 16;
    localparam int NN_IDX_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } scatter_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_scatter_16.sv
`default_nettype none
// ============================================================================
//  Module   : nn_scatter_16
//  Purpose  : Pops a serial stream of activations from a first-word-fall-
//             through FIFO and scatters them into 16 parallel lane registers
//             that feed the next layer's neuron inputs.
//  Ports    : clk        - rising-edge clock
//             reset      - synchronous active-high reset
//             start      - one-cycle fill request (honoured only in IDLE)
//             count      - lanes to fill; 0 = empty fill, >16 saturates
//             fifo_empty - FIFO empty flag
//             fifo_data  - FIFO head word (valid while not empty)
//             fifo_rd    - pop strobe (combinational)
//             lanes      - packed lane registers, lane i at [8i+7:8i]
//             lane_valid - bit i set once lane i written in current fill
//             busy       - high while a fill is in progress (LOAD/DONE)
//             done       - one-cycle pulse when the fill completes
//  Revision : 1.0  initial release
// ============================================================================
module nn_scatter_16
    import nn_pkg::*;
#(
    parameter int DATA_W  = NN_DATA_W,
    parameter int N_LANES = NN_LANES,
    parameter int IDX_W   = NN_IDX_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [4:0]                  count,
    input  logic                        fifo_empty,
    input  logic [DATA_W-1:0]           fifo_data,
    output logic                        fifo_rd,
    output logic [N_LANES*DATA_W-1:0]   lanes,
    output logic [N_LANES-1:0]          lane_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int c_CNT_W = IDX_W + 1;

    scatter_state_t         r_state;
    scatter_state_t         w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [c_CNT_W-1:0]     r_cnt_q;
    logic [c_CNT_W-1:0]     w_cnt_sat;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_last;

    // Requests above the lane count are clipped so cnt_q never exceeds 16.
    assign w_cnt_sat = (c_CNT_W'(count) > c_CNT_W'(N_LANES)) ? c_CNT_W'(N_LANES)
                                                              : c_CNT_W'(count);

    // LOAD is only entered with cnt_q >= 1, so cnt_q-1 never underflows there.
    assign w_last = ({1'b0, r_idx} == (r_cnt_q - c_CNT_W'(1)));

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        fifo_rd     = 1'b0;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (count == 5'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop = ~fifo_empty;
                // A 16-lane fill exits here on idx==15, never by index wrap.
                if (w_pop && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // No word may leave the FIFO while the block is being reset.
        fifo_rd = w_pop & ~reset;
    end

    // ------------------------------------------------------------------
    // Fill bookkeeping: latched lane count and write index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_cnt_q <= '0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_cnt_q <= w_cnt_sat;
        end else if (w_pop && !w_last) begin
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Lane array: one register per lane with its own write enable.
    // Data is kept across fills; only the valid flag is cleared on start.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        logic [DATA_W-1:0]  r_data;
        logic               r_valid;
        logic               w_we;

        assign w_we = w_pop && (r_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_valid <= 1'b0;
                end else if (w_we) begin
                    r_valid <= 1'b1;
                end
                if (w_we) begin
                    r_data <= fifo_data;
                end
            end
        end

        assign lanes[gi*DATA_W +: DATA_W] = r_data;
        assign lane_valid[gi]             = r_valid;
    end

endmodule : nn_scatter_16
`default_nettype wire

// File: tb/tb_nn_scatter_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nn_scatter_16
//  Purpose  : Self-checking bench for nn_scatter_16. A queue models the FWFT
//             FIFO; expected lane contents come from the queue head words
//             and the requested count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nn_scatter_16;

    logic           clk;
    logic           reset;
    logic           start;
    logic [4:0]     count;
    logic           fifo_empty;
    logic [7:0]     fifo_data;
    logic           fifo_rd;
    logic [127:0]   lanes;
    logic [15:0]    lane_valid;
    logic           busy;
    logic           done;

    nn_scatter_16 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .lanes      (lanes),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]     q[$];           // FIFO contents, q[0] is the head
    logic           hold_empty;     // forces the FIFO to look empty
    logic [7:0]     m_lanes[16];    // expected lane data
    logic [15:0]    m_valid;        // expected valid mask
    int             n_cmp;
    int             n_bad;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] packed_model();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_lanes[i];
        return v;
    endfunction

    task automatic drive_fifo();
        fifo_empty = hold_empty || (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    // One clock cycle: sample strobes before the edge, retire a pop after it.
    task automatic tick(output bit rd, output bit dn);
        drive_fifo();
        #1;
        rd = fifo_rd;
        dn = done;
        @(posedge clk);
        #1;
        if (rd && q.size() != 0) void'(q.pop_front());
        drive_fifo();
    endtask

    // Runs one fill and checks pops, latency, done pulse and lane contents.
    task automatic do_fill(input int cnt, input int stall_after, input int stall_len,
                           input int poke_cyc, input string tag);
        int n, pops_f, stall_ctr, stall_pops, done_cyc, c, exp_lat;
        bit rd, dn, got_done;
        n = (cnt > 16) ? 16 : cnt;
        pops_f = 0; stall_ctr = 0; stall_pops = 0; done_cyc = -1; c = 0;
        got_done = 1'b0;
        for (int i = 0; i < n; i++) m_lanes[i] = q[i];
        m_valid = '0;
        for (int i = 0; i < n; i++) m_valid[i] = 1'b1;

        count = 5'(cnt);
        start = 1'b1;
        tick(rd, dn);
        start = 1'b0;
        count = 5'($urandom);
        chk({tag, "_rd_in_idle"}, 128'(rd), 128'(0));

        while (!got_done && c < 200) begin
            c++;
            hold_empty = (pops_f == stall_after) && (stall_ctr < stall_len);
            if (hold_empty) stall_ctr++;
            if (c == poke_cyc) begin
                start = 1'b1;
                count = 5'd2;
            end
            tick(rd, dn);
            start = 1'b0;
            if (rd && hold_empty) stall_pops++;
            hold_empty = 1'b0;
            drive_fifo();
            if (rd) pops_f++;
            if (dn) begin
                got_done = 1'b1;
                done_cyc = c;
            end
        end

        exp_lat = n + 1 + ((stall_after >= 0 && stall_after < n) ? stall_len : 0);
        chk({tag, "_done_seen"},   128'(got_done),   128'(1));
        chk({tag, "_pops"},        128'(pops_f),     128'(n));
        chk({tag, "_stall_pops"},  128'(stall_pops), 128'(0));
        chk({tag, "_done_cycle"},  128'(done_cyc),   128'(exp_lat));
        chk({tag, "_busy_after"},  128'(busy),       128'(0));
        chk({tag, "_done_once"},   128'(done),       128'(0));
        chk({tag, "_lanes"},       lanes,            packed_model());
        chk({tag, "_valid"},       128'(lane_valid), 128'(m_valid));
        q.delete();
        drive_fifo();
    endtask

    initial begin
        bit rd, dn;
        int pops, cnt, n, extra, sa, sl;
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0; count = '0; hold_empty = 1'b0;
        for (int i = 0; i < 16; i++) m_lanes[i] = 8'h00;
        m_valid = '0;
        drive_fifo();
        tick(rd, dn);
        tick(rd, dn);
        reset = 1'b0;
        #1;
        chk("rst_lanes", lanes, 128'(0));
        chk("rst_valid", 128'(lane_valid), 128'(0));
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_done",  128'(done), 128'(0));
        chk("rst_rd",    128'(fifo_rd), 128'(0));

        // Reset in the middle of a 16-lane fill after five pops.
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h10 + i));
        count = 5'd16;
        start = 1'b1;
        tick(rd, dn);
        start = 1'b0;
        pops = 0;
        repeat (5) begin
            tick(rd, dn);
            if (rd) pops++;
        end
        chk("midrst_pops_before", 128'(pops), 128'(5));
        reset = 1'b1;
        tick(rd, dn);
        chk("midrst_rd_in_reset", 128'(rd), 128'(0));
        reset = 1'b0;
        #1;
        chk("midrst_lanes", lanes, 128'(0));
        chk("midrst_valid", 128'(lane_valid), 128'(0));
        chk("midrst_busy",  128'(busy), 128'(0));
        chk("midrst_rd",    128'(fifo_rd), 128'(0));
        chk("midrst_left",  128'(q.size()), 128'(11));
        q.delete();
        drive_fifo();

        // Full fill with an identity pattern.
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        do_fill(16, -1, 0, -1, "full");

        // Partial fill with a four-cycle FIFO underrun before the third word.
        q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3);
        do_fill(3, 2, 4, -1, "part");

        // Empty fill.
        do_fill(0, -1, 0, -1, "cnt0");

        // Oversized request saturates to 16 lanes.
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        do_fill(20, -1, 0, -1, "cnt20");

        // start during LOAD is ignored; start right after done is accepted.
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        do_fill(4, -1, 0, 2, "busy_start");
        for (int i = 0; i < 2; i++) q.push_back(8'($urandom));
        do_fill(2, -1, 0, -1, "b2b");

        // start coincident with done is not accepted (done at cycle 6).
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        do_fill(5, -1, 0, 6, "start_in_done");

        // Randomized fills with random underruns.
        for (int k = 0; k < 10; k++) begin
            cnt   = int'($urandom_range(0, 20));
            n     = (cnt > 16) ? 16 : cnt;
            extra = int'($urandom_range(0, 2));
            sa    = int'($urandom_range(0, 16));
            sl    = int'($urandom_range(0, 3));
            for (int i = 0; i < n + extra; i++) q.push_back(8'($urandom));
            do_fill(cnt, sa, sl, -1, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_nn_scatter_16
`default_nettype wire
